// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS channel: static pass-through when idle, stepped start->stop sweeps when busy.
// Optional macro SWEEP_PHASE_CLR_EN adds a phase_clr output that pulses with sweep_sync.
module dds_sweep_ctrl #(
    parameter int FW = 32,
    parameter int DW = 24,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] static_f_word,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    input  logic          mode_updown,
    input  logic [RW-1:0] repeat_n,
    input  logic [2:0]    wave_c_in,
    input  logic [4:0]    amplitude_in,
    input  logic          start,
    input  logic          abort,
    output logic [FW-1:0] f_word,
    output logic [2:0]    wave_c,
    output logic [4:0]    amplitude,
    output logic          busy,
    output logic          sweep_sync,
    output logic          done,
`ifdef SWEEP_PHASE_CLR_EN
    output logic          phase_clr,
`endif
    output logic          cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] f_word_q, f_word_d;
    logic [2:0]    wave_c_q, wave_c_d;
    logic [4:0]    amplitude_q, amplitude_d;
    logic          busy_q, busy_d;
    logic          sweep_sync_q, sweep_sync_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [RW-1:0] pass_cnt_q, pass_cnt_d;

    logic [FW-1:0] sh_start_q, sh_start_d;
    logic [FW-1:0] sh_stop_q, sh_stop_d;
    logic [FW-1:0] sh_step_q, sh_step_d;
    logic [DW-1:0] sh_dwell_q, sh_dwell_d;
    logic          sh_updown_q, sh_updown_d;
    logic [RW-1:0] sh_repeat_q, sh_repeat_d;

    logic [FW:0]   sum_up;
    logic [FW:0]   diff_dn;
    logic [DW-1:0] dwell_in_eff;
    logic          dwell_exp;
    logic          degenerate;
    logic          more_passes;
    logic          eop;

    assign sum_up       = {1'b0, f_word_q} + {1'b0, sh_step_q};
    assign diff_dn      = {1'b0, f_word_q} - {1'b0, sh_step_q};
    assign dwell_in_eff = (dwell == '0) ? DW'(1) : dwell;
    assign dwell_exp    = (dwell_cnt_q <= DW'(1));
    // A zero step or a single-point range would never reach the far end, so it ends after one dwell.
    assign degenerate   = (sh_step_q == '0) || (sh_start_q == sh_stop_q);
    assign more_passes  = (sh_repeat_q == '0) || (pass_cnt_q > RW'(1));

    always_comb begin
        state_d      = state_q;
        f_word_d     = f_word_q;
        wave_c_d     = wave_c_q;
        amplitude_d  = amplitude_q;
        sweep_sync_d = 1'b0;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;
        dwell_cnt_d  = dwell_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        sh_start_d   = sh_start_q;
        sh_stop_d    = sh_stop_q;
        sh_step_d    = sh_step_q;
        sh_dwell_d   = sh_dwell_q;
        sh_updown_d  = sh_updown_q;
        sh_repeat_d  = sh_repeat_q;
        eop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                f_word_d    = static_f_word;
                wave_c_d    = wave_c_in;
                amplitude_d = amplitude_in;
                if (start) begin
                    if (f_start > f_stop) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    sh_start_d   = f_start;
                    sh_stop_d    = f_stop;
                    sh_step_d    = f_step;
                    sh_dwell_d   = dwell_in_eff;
                    sh_updown_d  = mode_updown;
                    sh_repeat_d  = repeat_n;
                    // wave_c/amplitude registers double as the shadows until the sweep ends.
                    wave_c_d     = wave_c_in;
                    amplitude_d  = amplitude_in;
                    f_word_d     = f_start;
                    sweep_sync_d = 1'b1;
                    dwell_cnt_d  = dwell_in_eff;
                    pass_cnt_d   = repeat_n;
                    state_d      = S_UP;
                end
            end
            S_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dwell_exp) begin
                    dwell_cnt_d = sh_dwell_q;
                    if (degenerate || (f_word_q == sh_stop_q)) begin
                        eop = 1'b1;
                    end else if (sum_up[FW] || (sum_up[FW-1:0] >= sh_stop_q)) begin
                        f_word_d = sh_stop_q;
                        if (sh_updown_q) begin
                            state_d = S_DOWN;
                        end
                    end else begin
                        f_word_d = sum_up[FW-1:0];
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DW'(1);
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dwell_exp) begin
                    dwell_cnt_d = sh_dwell_q;
                    if (f_word_q == sh_start_q) begin
                        eop = 1'b1;
                    end else if (diff_dn[FW] || (diff_dn[FW-1:0] <= sh_start_q)) begin
                        f_word_d = sh_start_q;
                    end else begin
                        f_word_d = diff_dn[FW-1:0];
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DW'(1);
                end
            end
            S_DONE: begin
                f_word_d = static_f_word;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (eop) begin
            if (sh_repeat_q != '0) begin
                pass_cnt_d = pass_cnt_q - RW'(1);
            end
            if (more_passes) begin
                f_word_d     = sh_start_q;
                sweep_sync_d = 1'b1;
                state_d      = S_UP;
            end else begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_UP) || (state_d == S_DOWN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            f_word_q     <= '0;
            wave_c_q     <= '0;
            amplitude_q  <= '0;
            busy_q       <= 1'b0;
            sweep_sync_q <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            dwell_cnt_q  <= '0;
            pass_cnt_q   <= '0;
            sh_start_q   <= '0;
            sh_stop_q    <= '0;
            sh_step_q    <= '0;
            sh_dwell_q   <= '0;
            sh_updown_q  <= 1'b0;
            sh_repeat_q  <= '0;
        end else begin
            state_q      <= state_d;
            f_word_q     <= f_word_d;
            wave_c_q     <= wave_c_d;
            amplitude_q  <= amplitude_d;
            busy_q       <= busy_d;
            sweep_sync_q <= sweep_sync_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            dwell_cnt_q  <= dwell_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            sh_start_q   <= sh_start_d;
            sh_stop_q    <= sh_stop_d;
            sh_step_q    <= sh_step_d;
            sh_dwell_q   <= sh_dwell_d;
            sh_updown_q  <= sh_updown_d;
            sh_repeat_q  <= sh_repeat_d;
        end
    end

    assign f_word     = f_word_q;
    assign wave_c     = wave_c_q;
    assign amplitude  = amplitude_q;
    assign busy       = busy_q;
    assign sweep_sync = sweep_sync_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
`ifdef SWEEP_PHASE_CLR_EN
    assign phase_clr  = sweep_sync_q;
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: each task drives one scenario and checks hand-computed values.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] static_f_word, f_start, f_stop, f_step;
    logic [23:0] dwell;
    logic        mode_updown;
    logic [7:0]  repeat_n;
    logic [2:0]  wave_c_in;
    logic [4:0]  amplitude_in;
    logic        start, abort;
    logic [31:0] f_word;
    logic [2:0]  wave_c;
    logic [4:0]  amplitude;
    logic        busy, sweep_sync, done, cfg_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl dut (
        .clk(clk), .rst(rst), .static_f_word(static_f_word),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .mode_updown(mode_updown), .repeat_n(repeat_n), .wave_c_in(wave_c_in),
        .amplitude_in(amplitude_in), .start(start), .abort(abort),
        .f_word(f_word), .wave_c(wave_c), .amplitude(amplitude), .busy(busy),
        .sweep_sync(sweep_sync), .done(done), .cfg_err(cfg_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                       input logic [23:0] d, input logic m, input logic [7:0] r);
        f_start = s; f_stop = e; f_step = st; dwell = d; mode_updown = m; repeat_n = r;
    endtask

    // Returns just after the edge that samples start.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({f_word, wave_c, amplitude, busy, sweep_sync, done, cfg_err} !== '0) begin
            bad++;
            $display("FAIL reset outputs got f=%0h w=%0d a=%0d b=%0b s=%0b d=%0b e=%0b want all 0",
                     f_word, wave_c, amplitude, busy, sweep_sync, done, cfg_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        static_f_word = 32'h1234; wave_c_in = 3'd2; amplitude_in = 5'd7;
        tick();
        total++;
        if (f_word !== 32'h1234 || wave_c !== 3'd2 || amplitude !== 5'd7 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_track got f=%0h w=%0d a=%0d b=%0b want 1234 2 7 0", f_word, wave_c, amplitude, busy);
        end
    endtask

    task automatic test_sawtooth();
        int busy_cnt, sync_cnt, done_cnt;
        logic [31:0] expf;
        static_f_word = 32'h5555;
        cfg(100, 130, 10, 3, 1'b0, 8'd1);
        tick();
        pulse_start();
        total++;
        if (busy !== 1'b1 || f_word !== 32'h5555) begin
            bad++;
            $display("FAIL saw_load got busy=%0b f=%0h want 1 5555", busy, f_word);
        end
        busy_cnt = 1; sync_cnt = 0; done_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            busy_cnt += int'(busy); sync_cnt += int'(sweep_sync); done_cnt += int'(done);
            if (c <= 12) begin
                expf = 32'(100 + 10 * ((c - 1) / 3));
                total++;
                if (f_word !== expf) begin
                    bad++;
                    $display("FAIL saw_f c=%0d got %0d want %0d", c, f_word, expf);
                end
            end else if (c == 13) begin
                total++;
                if (done !== 1'b1 || busy !== 1'b0 || f_word !== 32'd130) begin
                    bad++;
                    $display("FAIL saw_done got done=%0b busy=%0b f=%0d want 1 0 130", done, busy, f_word);
                end
            end else begin
                total++;
                if (done !== 1'b0 || f_word !== 32'h5555) begin
                    bad++;
                    $display("FAIL saw_static got done=%0b f=%0h want 0 5555", done, f_word);
                end
            end
            // Start pulse while busy must be ignored.
            start = (c == 5);
        end
        start = 1'b0;
        total++;
        if (busy_cnt != 13 || sync_cnt != 1 || done_cnt != 1) begin
            bad++;
            $display("FAIL saw_counts got busy=%0d sync=%0d done=%0d want 13 1 1", busy_cnt, sync_cnt, done_cnt);
        end
    endtask

    task automatic test_updown();
        int sync_cnt, done_cnt, idx;
        logic [31:0] expf;
        cfg(100, 130, 10, 3, 1'b1, 8'd1);
        pulse_start();
        sync_cnt = 0; done_cnt = 0;
        for (int c = 1; c <= 22; c++) begin
            tick();
            sync_cnt += int'(sweep_sync); done_cnt += int'(done);
            idx = (c - 1) / 3;
            if (c <= 21) begin
                expf = (idx <= 3) ? 32'(100 + 10 * idx) : 32'(100 + 10 * (6 - idx));
                total++;
                if (f_word !== expf || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL updn_f c=%0d got %0d busy=%0b want %0d 1", c, f_word, busy, expf);
                end
            end else begin
                total++;
                if (done !== 1'b1) begin
                    bad++;
                    $display("FAIL updn_done got %0b want 1", done);
                end
            end
        end
        tick();
        total++;
        if (sync_cnt != 1 || done_cnt != 1) begin
            bad++;
            $display("FAIL updn_counts got sync=%0d done=%0d want 1 1", sync_cnt, done_cnt);
        end
    endtask

    task automatic test_overshoot();
        logic [31:0] ex [4];
        ex = '{32'd0, 32'd10, 32'd20, 32'd25};
        cfg(0, 25, 10, 2, 1'b0, 8'd1);
        pulse_start();
        for (int c = 1; c <= 9; c++) begin
            tick();
            total++;
            if (c <= 8) begin
                if (f_word !== ex[(c - 1) / 2]) begin
                    bad++;
                    $display("FAIL over_f c=%0d got %0d want %0d", c, f_word, ex[(c - 1) / 2]);
                end
            end else if (done !== 1'b1) begin
                bad++;
                $display("FAIL over_done got %0b want 1", done);
            end
        end
        tick();
    endtask

    task automatic test_carry();
        cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 1'b0, 8'd1);
        pulse_start();
        tick();
        total++;
        if (f_word !== 32'hFFFF_FFF0) begin
            bad++;
            $display("FAIL carry_start got %0h want fffffff0", f_word);
        end
        tick();
        total++;
        if (f_word !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL carry_clamp got %0h want ffffffff", f_word);
        end
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL carry_done got %0b want 1", done);
        end
        tick();
    endtask

    task automatic test_cfg_err();
        cfg(50, 40, 10, 1, 1'b0, 8'd1);
        pulse_start();
        total++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL cfgerr_pulse got err=%0b busy=%0b want 1 0", cfg_err, busy);
        end
        tick();
        total++;
        if (cfg_err !== 1'b0 || busy !== 1'b0 || sweep_sync !== 1'b0) begin
            bad++;
            $display("FAIL cfgerr_after got err=%0b busy=%0b sync=%0b want 0 0 0", cfg_err, busy, sweep_sync);
        end
    endtask

    task automatic test_degenerate();
        cfg(70, 90, 0, 0, 1'b0, 8'd1);
        pulse_start();
        tick();
        total++;
        if (f_word !== 32'd70 || busy !== 1'b1 || sweep_sync !== 1'b1) begin
            bad++;
            $display("FAIL step0_hold got f=%0d busy=%0b sync=%0b want 70 1 1", f_word, busy, sweep_sync);
        end
        tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL step0_done got done=%0b busy=%0b want 1 0", done, busy);
        end
        tick();
        cfg(55, 55, 5, 2, 1'b1, 8'd1);
        pulse_start();
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++;
            if (c <= 2 && (f_word !== 32'd55 || done !== 1'b0)) begin
                bad++;
                $display("FAIL equal_hold c=%0d got f=%0d done=%0b want 55 0", c, f_word, done);
            end else if (c == 3 && done !== 1'b1) begin
                bad++;
                $display("FAIL equal_done got %0b want 1", done);
            end
        end
        tick();
    endtask

    task automatic test_continuous_abort();
        int sync_cnt;
        logic [31:0] expf;
        cfg(10, 20, 10, 1, 1'b0, 8'd0);
        pulse_start();
        sync_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            sync_cnt += int'(sweep_sync);
            expf = (c % 2 == 1) ? 32'd10 : 32'd20;
            total++;
            if (f_word !== expf || sweep_sync !== logic'(c % 2 == 1) || done !== 1'b0) begin
                bad++;
                $display("FAIL cont_f c=%0d got f=%0d sync=%0b done=%0b want %0d %0b 0",
                         c, f_word, sweep_sync, done, expf, c % 2 == 1);
            end
        end
        total++;
        if (sync_cnt != 4) begin
            bad++;
            $display("FAIL cont_sync got %0d want 4", sync_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || f_word !== 32'd20) begin
            bad++;
            $display("FAIL cont_abort got busy=%0b done=%0b f=%0d want 0 0 20", busy, done, f_word);
        end
        tick();
        total++;
        if (f_word !== 32'h5555 || done !== 1'b0) begin
            bad++;
            $display("FAIL cont_static got f=%0h done=%0b want 5555 0", f_word, done);
        end
    endtask

    task automatic test_wave_hold();
        wave_c_in = 3'd3; amplitude_in = 5'd9;
        cfg(100, 130, 10, 4, 1'b0, 8'd2);
        pulse_start();
        tick();
        total++;
        if (wave_c !== 3'd3 || amplitude !== 5'd9) begin
            bad++;
            $display("FAIL wave_load got w=%0d a=%0d want 3 9", wave_c, amplitude);
        end
        wave_c_in = 3'd5; amplitude_in = 5'd17;
        repeat (4) tick();
        total++;
        if (wave_c !== 3'd3 || amplitude !== 5'd9 || f_word !== 32'd110) begin
            bad++;
            $display("FAIL wave_hold got w=%0d a=%0d f=%0d want 3 9 110", wave_c, amplitude, f_word);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || wave_c !== 3'd3 || f_word !== 32'd110) begin
            bad++;
            $display("FAIL wave_abort got busy=%0b done=%0b w=%0d f=%0d want 0 0 3 110", busy, done, wave_c, f_word);
        end
        tick();
        total++;
        if (wave_c !== 3'd5 || amplitude !== 5'd17 || f_word !== 32'h5555) begin
            bad++;
            $display("FAIL wave_idle got w=%0d a=%0d f=%0h want 5 17 5555", wave_c, amplitude, f_word);
        end
    endtask

    task automatic test_reset_mid();
        cfg(100, 130, 10, 3, 1'b0, 8'd1);
        pulse_start();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({f_word, wave_c, amplitude, busy, sweep_sync, done, cfg_err} !== '0) begin
            bad++;
            $display("FAIL rst_mid got f=%0h w=%0d a=%0d b=%0b want all 0", f_word, wave_c, amplitude, busy);
        end
        tick();
        total++;
        if (f_word !== 32'h5555 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle got f=%0h busy=%0b want 5555 0", f_word, busy);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        static_f_word = '0; wave_c_in = '0; amplitude_in = '0;
        cfg(0, 0, 0, 0, 1'b0, 8'd0);
        test_reset();
        test_idle();
        test_sawtooth();
        test_updown();
        test_overshoot();
        test_carry();
        test_cfg_err();
        test_degenerate();
        test_continuous_abort();
        test_wave_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
